// File: rtl/ga_result_streamer.sv
// Streams a captured GA result as a framed byte sequence: header, LEN genes, fitness, XOR checksum.
// A frame is launched on each rising edge of ga_done seen while idle; edges while busy flag overrun.
module ga_result_streamer #(
  parameter int          LEN      = 12,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ga_done,
  input  logic [7:0] ga_best_gen [LEN],
  input  logic [6:0] ga_fitness,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       overrun,
  output logic [7:0] frame_count
);

  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);

  typedef enum logic [2:0] {IDLE, HDR, DATA, FIT, CSUM} state_t;

  state_t        state, state_nxt;
  logic          ga_done_q;
  logic          rise;
  logic [IW-1:0] idx;
  logic [7:0]    csum;
  logic [7:0]    gene [LEN];
  logic [6:0]    fit;

  assign rise = ga_done && !ga_done_q;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Every non-idle state presents a valid byte, so out_ready alone is the handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise)                           state_nxt = HDR;
      HDR:     if (out_ready)                      state_nxt = DATA;
      DATA:    if (out_ready && idx == LAST_IDX)   state_nxt = FIT;
      FIT:     if (out_ready)                      state_nxt = CSUM;
      CSUM:    if (out_ready)                      state_nxt = IDLE;
      default:                                     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_data  = 8'h00;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state)
      HDR:  begin out_valid = 1'b1; busy = 1'b1; out_data = HDR_BYTE;       end
      DATA: begin out_valid = 1'b1; busy = 1'b1; out_data = gene[idx];      end
      FIT:  begin out_valid = 1'b1; busy = 1'b1; out_data = {1'b0, fit};    end
      CSUM: begin out_valid = 1'b1; busy = 1'b1; out_data = csum;
                  out_last  = 1'b1;                                         end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ga_done_q   <= 1'b0;
      idx         <= '0;
      csum        <= 8'h00;
      overrun     <= 1'b0;
      frame_count <= 8'h00;
    end else begin
      ga_done_q <= ga_done;
      if (rise && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (rise) begin
          csum <= 8'h00;
          idx  <= '0;
        end
        DATA: if (out_ready) begin
          csum <= csum ^ gene[idx];
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        FIT:  if (out_ready) csum <= csum ^ {1'b0, fit};
        CSUM: if (out_ready) frame_count <= frame_count + 8'd1;
        default: ;
      endcase
    end
  end

  // Snapshot of the result; only loaded on a launching edge, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && rise) begin
      gene <= ga_best_gen;
      fit  <= ga_fitness;
    end
  end

endmodule

// File: tb/tb_ga_result_streamer.sv
// Self-checking bench for ga_result_streamer: table of frame cases, corner sequences, random frames.
module tb_ga_result_streamer;

  localparam int LEN = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ga_done = 1'b0;
  logic [7:0] ga_best_gen [LEN];
  logic [6:0] ga_fitness = 7'd0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic       busy;
  logic       overrun;
  logic [7:0] frame_count;

  ga_result_streamer #(.LEN(LEN), .HDR_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .ga_done(ga_done), .ga_best_gen(ga_best_gen),
    .ga_fitness(ga_fitness), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .overrun(overrun), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q [$];
  logic [7:0] exp_fc = 8'd0;
  logic       exp_ovr = 1'b0;
  logic [7:0] last_byte;

  typedef struct {
    int         gmode;
    logic [6:0] fit;
    int         rmode;
    logic [7:0] csum;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: header, genes, fitness, then XOR of every byte after the header.
  task automatic build_exp();
    logic [7:0] x;
    x = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < LEN; i++) begin
      exp_q.push_back(ga_best_gen[i]);
      x ^= ga_best_gen[i];
    end
    exp_q.push_back({1'b0, ga_fitness});
    x ^= {1'b0, ga_fitness};
    exp_q.push_back(x);
  endtask

  task automatic set_genes(input int gmode);
    string s;
    s = "Hello World!";
    for (int i = 0; i < LEN; i++) begin
      case (gmode)
        0: ga_best_gen[i] = s[i];
        1: ga_best_gen[i] = 8'h00;
        2: ga_best_gen[i] = 8'hFF;
        3: ga_best_gen[i] = 8'(i);
        default: ga_best_gen[i] = 8'($urandom);
      endcase
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ga_done = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_fcount", frame_count, 0);
    rst = 1'b1;
    exp_fc = 8'd0;
    exp_ovr = 1'b0;
  endtask

  // Called at a negedge: drops ga_done one cycle, raises it and checks the one-clock launch latency.
  task automatic start_frame();
    ga_done = 1'b0;
    @(negedge clk);
    build_exp();
    chk("idle_valid", out_valid, 0);
    ga_done = 1'b1;
    @(negedge clk);
    chk("launch_valid", out_valid, 1);
  endtask

  // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random. pulse_at: accepted-byte count at which
  // ga_done is pulsed low for one cycle. stop_at: return once this many bytes are accepted.
  task automatic stream(input int rmode, input int pulse_at, input int stop_at, input bit scramble);
    int n, cyc, pst;
    bit r, stalled;
    logic [7:0] pd;
    logic pl;
    n = 0; cyc = 0; pst = 0; stalled = 0; pd = 8'h00; pl = 1'b0;
    while (n < stop_at && cyc < 400) begin
      chk("valid_cont", out_valid, 1);
      chk("busy_cont", busy, 1);
      if (stalled) begin
        chk("stall_data", out_data, pd);
        chk("stall_last", out_last, pl);
      end
      case (rmode)
        0: r = 1'b1;
        1: r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (pst == 1) begin
        ga_done = 1'b1;
        pst = 2;
        exp_ovr = 1'b1;
      end else if (n == pulse_at && pst == 0) begin
        ga_done = 1'b0;
        pst = 1;
      end
      if (scramble) begin
        for (int i = 0; i < LEN; i++) ga_best_gen[i] = 8'($urandom);
        ga_fitness = 7'($urandom);
      end
      out_ready = r;
      if (r) begin
        chk("data", out_data, exp_q[n]);
        chk("last", out_last, (n == LEN + 2) ? 1 : 0);
        last_byte = out_data;
        n++;
      end
      stalled = !r;
      pd = out_data;
      pl = out_last;
      cyc++;
      @(negedge clk);
    end
    if (n < stop_at) chk("stream_timeout", n, stop_at);
    if (n == LEN + 3) exp_fc = exp_fc + 8'd1;
  endtask

  task automatic end_checks();
    chk("end_valid", out_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_last", out_last, 0);
    chk("end_fcount", frame_count, exp_fc);
    chk("end_overrun", overrun, exp_ovr);
  endtask

  task automatic idle_for(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chk("no_frame", out_valid, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    tbl[0] = '{0, 7'd100, 0, 8'h65};
    tbl[1] = '{0, 7'd100, 1, 8'h65};
    tbl[2] = '{1, 7'd0,   2, 8'h00};
    tbl[3] = '{2, 7'd100, 0, 8'h64};
    tbl[4] = '{3, 7'd1,   1, 8'h01};

    set_genes(0);
    do_reset();

    foreach (tbl[k]) begin
      set_genes(tbl[k].gmode);
      ga_fitness = tbl[k].fit;
      start_frame();
      stream(tbl[k].rmode, -1, LEN + 3, 1'b0);
      chk("tbl_csum", last_byte, tbl[k].csum);
      end_checks();
    end

    // ga_done held high: edge-triggered, so no further frame until it is re-armed.
    idle_for(100);
    chk("held_fcount", frame_count, exp_fc);
    set_genes(9);
    ga_fitness = 7'd42;
    start_frame();
    stream(0, -1, LEN + 3, 1'b1);
    end_checks();

    // Glitch on ga_done while streaming gene 5: frame unaffected, overrun latched.
    set_genes(9);
    ga_fitness = 7'd77;
    start_frame();
    stream(0, 6, LEN + 3, 1'b0);
    end_checks();
    idle_for(20);

    // Reset during FIT aborts; ga_done still high relaunches a fresh frame.
    set_genes(0);
    ga_fitness = 7'd100;
    start_frame();
    stream(0, -1, LEN + 1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_fcount", frame_count, 0);
    chk("abort_overrun", overrun, 0);
    exp_fc = 8'd0;
    exp_ovr = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("relaunch_valid", out_valid, 1);
    chk("relaunch_hdr", out_data, 8'hA5);
    build_exp();
    stream(0, -1, LEN + 3, 1'b0);
    end_checks();

    // Rising edge coinciding with acceptance of the checksum byte.
    set_genes(9);
    start_frame();
    stream(0, LEN + 1, LEN + 3, 1'b0);
    end_checks();
    idle_for(10);

    do_reset();
    for (int f = 0; f < 20; f++) begin
      set_genes(9);
      ga_fitness = 7'($urandom_range(0, 100));
      start_frame();
      stream(2, -1, LEN + 3, 1'b1);
      end_checks();
    end

    do_reset();
    for (int f = 0; f < 256; f++) begin
      set_genes(9);
      ga_fitness = 7'($urandom_range(0, 100));
      start_frame();
      stream(0, -1, LEN + 3, 1'b0);
      if (f == 254) chk("fcount_255", frame_count, 8'd255);
    end
    chk("fcount_wrap", frame_count, 8'd0);
    end_checks();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
